// File: rtl/spi_reg_decoder.sv
// rtl/spi_reg_decoder.sv - SPI byte-stream to register-file transaction controller
// First byte of a CS frame is the command; later bytes are write data or read dummies.
module spi_reg_decoder #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e            state_q;
  logic              cs_s1_q, cs_s2_q, cs_s3_q;
  logic              rw_q, inc_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              rd_pend_q, rd_inv_q, cap_q, cap_zero_q;
  logic [7:0]        data_out_q, reg_wdata_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic              reg_we_q, reg_re_q, busy_q, err_q;

  logic [ADDR_W-1:0] cmd_addr_d, step_addr_d;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  assign cmd_addr_d  = data_in[ADDR_W-1:0];
  assign step_addr_d = inc_q ? ptr_q + ADDR_W'(1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_s3_q     <= 1'b1;
      rw_q        <= 1'b0;
      inc_q       <= 1'b0;
      ptr_q       <= '0;
      rd_pend_q   <= 1'b0;
      rd_inv_q    <= 1'b0;
      cap_q       <= 1'b0;
      cap_zero_q  <= 1'b0;
      data_out_q  <= 8'h00;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_s1_q    <= cs_n;
      cs_s2_q    <= cs_s1_q;
      cs_s3_q    <= cs_s2_q;
      reg_we_q   <= 1'b0;
      reg_re_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      // Read pipeline: strobe, then regfile answers, then capture into data_out.
      cap_q      <= rd_pend_q;
      cap_zero_q <= rd_inv_q;
      if (cap_q) data_out_q <= cap_zero_q ? 8'h00 : reg_rdata;

      case (state_q)
        IDLE: begin
          if (cs_s3_q && !cs_s2_q) begin
            state_q <= CMD;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        default: begin
          if (byte_sync) begin
            if (state_q == CMD) begin
              rw_q       <= data_in[7];
              inc_q      <= data_in[6];
              ptr_q      <= cmd_addr_d;
              reg_addr_q <= cmd_addr_d;
              if (!data_in[7]) begin
                rd_pend_q <= 1'b1;
                rd_inv_q  <= !addr_ok(cmd_addr_d);
                reg_re_q  <= addr_ok(cmd_addr_d);
                if (!addr_ok(cmd_addr_d)) err_q <= 1'b1;
              end
            end else if (rw_q) begin
              reg_addr_q  <= ptr_q;
              reg_wdata_q <= data_in;
              reg_we_q    <= addr_ok(ptr_q);
              if (!addr_ok(ptr_q)) err_q <= 1'b1;
              ptr_q       <= step_addr_d;
            end else begin
              ptr_q      <= step_addr_d;
              reg_addr_q <= step_addr_d;
              rd_pend_q  <= 1'b1;
              rd_inv_q   <= !addr_ok(step_addr_d);
              reg_re_q   <= addr_ok(step_addr_d);
              if (!addr_ok(step_addr_d)) err_q <= 1'b1;
            end
            if (!cs_s2_q) state_q <= DATA;
          end
          // A byte arriving with the deassert is still handled above before leaving.
          if (cs_s2_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_spi_reg_decoder.sv
// tb/tb_spi_reg_decoder.sv - scoreboard bench for spi_reg_decoder
// Frames are modelled as byte lists; expected strobes are queued and checked by a monitor.
module tb_spi_reg_decoder;
  localparam int NR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy, err;

  spi_reg_decoder #(.NUM_REGS(NR), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync), .data_in(data_in),
    .data_out(data_out), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file attached to the DUT: registered read data.
  logic       init_mem = 1'b1;
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 5);
    end else begin
      if (reg_we) mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= mem[reg_addr];
    end
  end

  // Reference state.
  logic [7:0]  ref_mem [64];
  logic [13:0] wr_q [$];
  logic [13:0] rd_q [$];
  logic [7:0]  m_dout = 8'h00;
  logic        m_err = 1'b0;
  logic [7:0]  fb [8];

  // Monitor: pops expectations whenever a strobe appears.
  int         lat_cnt = 0;
  logic [7:0] lat_exp = 8'h00;
  always @(negedge clk) begin
    logic [13:0] e;
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) chk("data_out_latency", data_out, lat_exp);
    end
    if (reg_we || reg_re) chk("we_re_exclusive", reg_we & reg_re, 0);
    if (reg_we) begin
      if (wr_q.size() == 0) chk("unexpected_we", 1, 0);
      else begin
        e = wr_q.pop_front();
        chk("we_addr", reg_addr, e[13:8]);
        chk("we_data", reg_wdata, e[7:0]);
      end
    end
    if (reg_re) begin
      if (rd_q.size() == 0) chk("unexpected_re", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("re_addr", reg_addr, e[13:8]);
        lat_exp = e[7:0];
        lat_cnt = 2;
      end
    end
  end

  task automatic model_read(input logic [5:0] a);
    if (int'(a) < NR) begin
      rd_q.push_back({a, ref_mem[a]});
      m_dout = ref_mem[a];
    end else begin
      m_err  = 1'b1;
      m_dout = 8'h00;
    end
  endtask

  task automatic pulse(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in   = b;
    @(negedge clk);
    byte_sync = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_reg_re"}, reg_re, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic run_frame(input int n, input bit late);
    logic       rw, inc;
    logic [5:0] a;
    rw    = fb[0][7];
    inc   = fb[0][6];
    a     = fb[0][5:0];
    m_err = 1'b0;
    if (!rw) model_read(a);
    for (int i = 1; i < n; i++) begin
      if (rw) begin
        if (int'(a) < NR) begin
          wr_q.push_back({a, fb[i]});
          ref_mem[a] = fb[i];
        end else m_err = 1'b1;
        if (inc) a = a + 6'd1;
      end else begin
        if (inc) a = a + 6'd1;
        model_read(a);
      end
    end

    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_in_frame", busy, 1);
    chk("err_cleared_at_start", err, 0);
    for (int i = 0; i < n; i++) begin
      if (late && i == n - 1) break;
      pulse(fb[i]);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    cs_n = 1'b1;
    if (late) begin
      // Lands in the cycle the synchronised deassert is first seen.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      pulse(fb[n - 1]);
    end
    repeat (5) @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("err_after_frame", err, m_err);
    chk("data_out_after_frame", data_out, m_dout);
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_reads", rd_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n    = 1'b1;
    init_mem = 1'b0;
    repeat (3) @(negedge clk);

    fb[0] = 8'h85; fb[1] = 8'hA5; run_frame(2, 1'b0);
    fb[0] = 8'h83; fb[1] = 8'h3C; run_frame(2, 1'b0);
    fb[0] = 8'h03; run_frame(1, 1'b0);
    fb[0] = 8'hFE; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33; run_frame(4, 1'b0);
    fb[0] = 8'hCE; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03; run_frame(4, 1'b0);
    fb[0] = 8'h4D; fb[1] = 8'h00; fb[2] = 8'h00; fb[3] = 8'h00; run_frame(4, 1'b0);
    fb[0] = 8'h94; fb[1] = 8'h77; run_frame(2, 1'b0);
    fb[0] = 8'h02; fb[1] = 8'h00; run_frame(2, 1'b0);

    // Reset in the middle of a write frame.
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    pulse(8'h85);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midreset");
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_dout = 8'h00;
    repeat (5) @(negedge clk);
    check_reset_vals("post_reset");

    fb[0] = 8'h81; run_frame(1, 1'b0);
    fb[0] = 8'h85; fb[1] = 8'h5A; run_frame(2, 1'b0);
    fb[0] = 8'h87; fb[1] = 8'hC3; run_frame(2, 1'b1);
    fb[0] = 8'h07; run_frame(1, 1'b1);

    for (int f = 0; f < 40; f++) begin
      int n;
      logic [5:0] a;
      n = $urandom_range(1, 5);
      a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 17));
      fb[0] = {1'($urandom), 1'($urandom), a};
      for (int i = 1; i < n; i++) fb[i] = 8'($urandom);
      run_frame(n, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        pulse(8'($urandom));
        repeat (3) @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
